pingpong_sel_loader: RTL

Upstream feeder for the parity-select mux. Accepts a single valid/ready word stream and steers consecutive words alternately into two lane registers, `data_a` then `data_b`. It produces the 5-bit `sel` whose parity points at the lane holding the oldest unread word, so the downstream mux output (`sel` even selects `data_a`, odd selects `data_b`) is always the next word in arrival order. Provides two-entry buffering with back-pressure, and a `wrap` marker each time `sel` rolls over.

---
 rtl/pingpong_pkg.sv | 12 +
 rtl/pingpong_lane.sv | 42 ++++
 rtl/pingpong_sel_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong select loader: widths, defaults and the lane enum.
package pingpong_pkg;

    localparam int SEL_W     = 5;
    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_e;

endpackage

// File: rtl/pingpong_lane.sv
// One lane of the ping-pong buffer: a data register and its full flag.
module pingpong_lane
    import pingpong_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Data survives clr and unload; only rst or a new load changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_full <= 1'b0;
        end else if (load) begin
            r_full <= 1'b1;
        end else if (unload) begin
            r_full <= 1'b0;
        end
    end

    assign data = r_data;
    assign full = r_full;

endmodule

// File: rtl/pingpong_sel_loader.sv
// Steers a valid/ready stream alternately into two lanes and drives the parity-select counter.
module pingpong_sel_loader
    import pingpong_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SEL_MAX = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    output logic             wrap,
    output logic [1:0]       occupancy
);

    generate
        if ((SEL_MAX % 2) != 1 || SEL_MAX > 31 || SEL_MAX < 1) begin : g_bad_sel_max
            $error("pingpong_sel_loader: SEL_MAX must be odd and in 1..31");
        end
    endgenerate

    lane_e            r_wp;
    logic [SEL_W-1:0] r_sel;
    logic             r_wrap;

    logic  w_full_a, w_full_b;
    logic  w_full_wp, w_full_rd;
    lane_e w_rd_lane;
    logic  w_wr, w_rd, w_at_max;
    logic  w_load_a, w_load_b, w_unload_a, w_unload_b;

    always_comb begin
        w_rd_lane  = (r_sel[0] == 1'b0) ? LANE_A : LANE_B;
        w_full_wp  = (r_wp == LANE_A) ? w_full_a : w_full_b;
        w_full_rd  = (w_rd_lane == LANE_A) ? w_full_a : w_full_b;
        in_ready   = !w_full_wp && !rst && !flush;
        out_valid  = w_full_rd;
        w_wr       = in_valid && in_ready;
        // flush/rst override a read handshake so sel never advances under them
        w_rd       = w_full_rd && out_ready && !flush && !rst;
        w_at_max   = (r_sel == SEL_W'(SEL_MAX));
        w_load_a   = w_wr && (r_wp == LANE_A);
        w_load_b   = w_wr && (r_wp == LANE_B);
        w_unload_a = w_rd && (w_rd_lane == LANE_A);
        w_unload_b = w_rd && (w_rd_lane == LANE_B);
    end

    pingpong_lane #(.WIDTH(WIDTH)) u_lane_a (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .load    (w_load_a),
        .unload  (w_unload_a),
        .in_data (in_data),
        .data    (data_a),
        .full    (w_full_a)
    );

    pingpong_lane #(.WIDTH(WIDTH)) u_lane_b (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .load    (w_load_b),
        .unload  (w_unload_b),
        .in_data (in_data),
        .data    (data_b),
        .full    (w_full_b)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wp   <= LANE_A;
            r_sel  <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= (r_wp == LANE_A) ? LANE_B : LANE_A;
            end
            if (w_rd) begin
                r_sel <= w_at_max ? '0 : r_sel + SEL_W'(1);
            end
            r_wrap <= w_rd && w_at_max;
        end
    end

    assign sel       = r_sel;
    assign wrap      = r_wrap;
    assign occupancy = {1'b0, w_full_a} + {1'b0, w_full_b};

endmodule
